// File: rtl/ram_port_arbiter_if.sv
// Requester/Ram bundle for the two-port data-Ram arbiter.
// master = requesters plus the Ram itself; slave = the arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;

    logic [DW-1:0] rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with a consecutive-grant cap sharing one single-port Ram
// between CPU data (port 0) and the message/DMA engine (port 1).
module ram_port_arbiter #(
    parameter int unsigned AW        = 10,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst,
    ram_port_arbiter_if.slave bus
);
    localparam int unsigned   CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    logic          last_q;
    logic          last_d;
    logic [CW-1:0] burst_q;
    logic [CW-1:0] burst_d;
    logic [1:0]    rtag_q;
    logic [1:0]    rtag_d;

    logic          gnt0_c;
    logic          gnt1_c;
    logic          stay_c;
    logic          pick_c;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    // Grant: a nonzero burst count means last's port was granted the previous
    // cycle, so under contention it keeps the Ram until the cap is reached.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        stay_c = (burst_q != '0) && (burst_q < BURST_MAX);
        pick_c = stay_c ? last_q : ~last_q;
        if (!rst) begin
            case ({bus.req1, bus.req0})
                2'b01:   gnt0_c = 1'b1;
                2'b10:   gnt1_c = 1'b1;
                2'b11: begin
                    gnt1_c = pick_c;
                    gnt0_c = ~pick_c;
                end
                default: begin
                    gnt0_c = 1'b0;
                    gnt1_c = 1'b0;
                end
            endcase
        end
    end

    // Next state: burst accounting, last-granted port and read-return tag.
    always_comb begin
        last_d  = last_q;
        burst_d = burst_q;
        rtag_d  = {gnt1_c & ~bus.we1, gnt0_c & ~bus.we0};
        if (gnt0_c || gnt1_c) begin
            if (gnt1_c == last_q) begin
                burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + CW'(1);
            end else begin
                burst_d = CW'(1);
            end
            last_d = gnt1_c;
        end else begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= 1'b1;
            burst_q <= '0;
            rtag_q  <= 2'b00;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
            rtag_q  <= rtag_d;
        end
    end

    // Ram issue path; idle cycles leave port 0's fields on the bus.
    assign addr_mux  = gnt1_c ? bus.addr1  : bus.addr0;
    assign wdata_mux = gnt1_c ? bus.wdata1 : bus.wdata0;

    assign bus.ram_addr  = addr_mux;
    assign bus.ram_wdata = wdata_mux;
    assign bus.ram_we    = (gnt0_c & bus.we0) | (gnt1_c & bus.we1);

    assign bus.gnt0    = gnt0_c;
    assign bus.gnt1    = gnt1_c;
    assign bus.rvalid0 = rtag_q[0];
    assign bus.rvalid1 = rtag_q[1];
    assign bus.rdata   = bus.ram_rdata;
endmodule
